// File: rtl/rw_seed_sequencer_pkg.sv
// rtl/rw_seed_sequencer_pkg.sv - shared PathORAM constants: FSM encoding and width helpers
// Purpose: state encoding and IV/BID/level width helpers used by the seed sequencer.
// Ports: none (package).
package rw_seed_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Bits needed to hold a tree level 0..oraml.
    function automatic int level_width(input int oraml);
        return (oraml < 1) ? 1 : $clog2(oraml + 1);
    endfunction

    // Heap-order bucket index of a depth-oraml tree needs oraml+1 bits.
    function automatic int bid_width(input int oraml);
        return oraml + 1;
    endfunction

    function automatic int iv_width(input int aes_entropy);
        return aes_entropy;
    endfunction

endpackage

// File: rtl/bkt_index_calc.sv
// rtl/bkt_index_calc.sv - heap-order bucket index of a leaf path at a given level
// Purpose: combinational BID = (2^level - 1) + (leaf >> (ORAML - level)).
// Ports: i_leaf (ORAML bits), i_level (tree level), o_bid (ORAML+1 bits).
module bkt_index_calc
    import rw_seed_sequencer_pkg::*;
#(
    parameter int ORAML = 16
) (
    input  logic [ORAML-1:0]                i_leaf,
    input  logic [level_width(ORAML)-1:0]   i_level,
    output logic [bid_width(ORAML)-1:0]     o_bid
);

    localparam int LW = level_width(ORAML);
    localparam logic [ORAML:0] ONE = {{ORAML{1'b0}}, 1'b1};

    logic [ORAML:0] w_base;
    logic [ORAML:0] w_path;
    logic [LW-1:0]  w_shift;

    // First index of the level, plus the leaf's ancestor offset within it.
    assign w_base  = (ONE << i_level) - ONE;
    assign w_shift = LW'(ORAML) - i_level;
    assign w_path  = {1'b0, i_leaf} >> w_shift;
    assign o_bid   = w_base + w_path;

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - loadable up-counter primitive
// Purpose: generic loadable incrementing counter; load has priority over increment.
// Ports: i_clk, i_rst (async, active-high), i_load, i_load_value, i_inc, o_count.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rw_seed_sequencer.sv
// rtl/rw_seed_sequencer.sv - per-bucket IV/BID sequencer for PathORAM read/write phases
// Purpose: walks one path per eviction (read phase then write phase), emitting one
//   registered beat per bucket with its IV seed, heap index and level.
// Ports: i_Clock, i_Reset (async, active-high), i_Enable, i_ReverseLex,
//   o_OutIV, o_OutBID, o_OutLevel, o_OutWrite, o_OutValid, i_OutReady,
//   o_PathDone (pulse on last write transfer), o_Overflow (sticky G wrap).
module rw_seed_sequencer
    import rw_seed_sequencer_pkg::*;
#(
    parameter int ORAML      = 16,
    parameter int AESEntropy = 64,
    parameter int TopLevels  = 0
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset,
    input  logic                              i_Enable,
    input  logic                              i_ReverseLex,
    output logic [iv_width(AESEntropy)-1:0]   o_OutIV,
    output logic [bid_width(ORAML)-1:0]       o_OutBID,
    output logic [level_width(ORAML)-1:0]     o_OutLevel,
    output logic                              o_OutWrite,
    output logic                              o_OutValid,
    input  logic                              i_OutReady,
    output logic                              o_PathDone,
    output logic                              o_Overflow
);

    localparam int LW = level_width(ORAML);
    localparam logic [LW-1:0] LVL_TOP  = LW'(TopLevels);
    localparam logic [LW-1:0] LVL_LAST = LW'(ORAML);

    logic [1:0]            r_state;
    logic                  r_valid;
    logic [AESEntropy-1:0] r_g;
    logic [ORAML-1:0]      r_leaf;
    logic                  r_overflow;
    logic [AESEntropy-1:0] r_iv;
    logic [ORAML:0]        r_bid;
    logic                  r_write;

    logic [LW-1:0]         w_level;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_path_end;
    logic                  w_to_write;
    logic                  w_step;
    logic                  w_start;
    logic                  w_load_out;
    logic [AESEntropy-1:0] w_g_next;
    logic [AESEntropy-1:0] w_g_src;
    logic [ORAML-1:0]      w_rev_leaf;
    logic [ORAML-1:0]      w_nxt_leaf;
    logic [LW-1:0]         w_nxt_level;
    logic                  w_nxt_write;
    logic [AESEntropy-1:0] w_nxt_iv;
    logic [ORAML:0]        w_nxt_bid;

    assign w_xfer     = r_valid & i_OutReady;
    assign w_last     = (w_level == LVL_LAST);
    assign w_path_end = w_xfer & w_last & (r_state == ST_WRITE);
    assign w_to_write = w_xfer & w_last & (r_state == ST_READ);
    assign w_step     = w_xfer & ~w_last;
    assign w_start    = ((r_state == ST_IDLE) & i_Enable) | (w_path_end & i_Enable);
    assign w_load_out = w_start | w_to_write | w_step;

    // A back-to-back read phase must already see the incremented G.
    assign w_g_next = r_g + AESEntropy'(1);
    assign w_g_src  = w_path_end ? w_g_next : r_g;

    always_comb begin
        w_rev_leaf = '0;
        for (int i = 0; i < ORAML; i++) begin
            w_rev_leaf[i] = w_g_src[ORAML-1-i];
        end
    end

    // Leaf is only re-chosen at read-phase start; the write phase reuses it.
    assign w_nxt_leaf  = w_start ? (i_ReverseLex ? w_rev_leaf : w_g_src[ORAML-1:0]) : r_leaf;
    assign w_nxt_level = w_step ? (w_level + 1'b1) : LVL_TOP;
    assign w_nxt_write = w_to_write ? 1'b1 : (w_step ? r_write : 1'b0);
    assign w_nxt_iv    = (w_g_src >> w_nxt_level) + AESEntropy'(w_nxt_write);

    bkt_index_calc #(
        .ORAML (ORAML)
    ) u_bkt_index_calc (
        .i_leaf  (w_nxt_leaf),
        .i_level (w_nxt_level),
        .o_bid   (w_nxt_bid)
    );

    counter #(
        .WIDTH (LW)
    ) u_level_counter (
        .i_clk        (i_Clock),
        .i_rst        (i_Reset),
        .i_load       (w_start | w_to_write),
        .i_load_value (LVL_TOP),
        .i_inc        (w_step),
        .o_count      (w_level)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_g        <= '0;
            r_leaf     <= '0;
            r_overflow <= 1'b0;
            r_iv       <= '0;
            r_bid      <= '0;
            r_write    <= 1'b0;
        end else begin
            if (w_start) begin
                r_state <= ST_READ;
                r_valid <= 1'b1;
            end else if (w_to_write) begin
                r_state <= ST_WRITE;
            end else if (w_path_end) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end
            if (w_load_out) begin
                r_leaf  <= w_nxt_leaf;
                r_iv    <= w_nxt_iv;
                r_bid   <= w_nxt_bid;
                r_write <= w_nxt_write;
            end
            if (w_path_end) begin
                r_g <= w_g_next;
                if (&r_g) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_OutIV    = r_iv;
    assign o_OutBID   = r_bid;
    assign o_OutLevel = w_level;
    assign o_OutWrite = r_write;
    assign o_OutValid = r_valid;
    assign o_PathDone = w_path_end;
    assign o_Overflow = r_overflow;

endmodule

// File: doc/rw_seed_sequencer.md
RW_SEED_SEQUENCER -- requirements
Module: rw_seed_sequencer

Interface
REQ-001 Parameter ORAML, default 16: tree depth in levels below the root; a path holds ORAML+1 buckets.
REQ-002 Parameter AESEntropy, default 64: width of the eviction counter and of the emitted IV.
REQ-003 Parameter TopLevels, default 0, legal range 0..ORAML: levels 0..TopLevels-1 are cached on-chip and are never emitted.
REQ-004 Clock  in  1  system clock; all state changes on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Enable  in  1  permits a new path (read phase) to start.
REQ-007 ReverseLex  in  1  leaf-order select, sampled at read-phase start: 0 = sequential, 1 = bit-reversed.
REQ-008 OutIV  out  AESEntropy  IV seed for the current bucket.
REQ-009 OutBID  out  ORAML+1  heap-order bucket index (root = 0).
REQ-010 OutLevel  out  clog2(ORAML+1)  tree level of the current bucket.
REQ-011 OutWrite  out  1  0 = read (decrypt) bucket, 1 = write (encrypt) bucket.
REQ-012 OutValid  out  1 / OutReady  in  1  valid/ready handshake for the output beat.
REQ-013 PathDone  out  1  one-cycle pulse on the cycle the last write beat transfers.
REQ-014 Overflow  out  1  sticky flag: the eviction counter G has wrapped.

Function
REQ-015 Transfer SHALL be OutValid && OutReady.
REQ-016 All Out* signals SHALL be registered and SHALL hold stable while OutValid=1 and OutReady=0.
REQ-017 FSM states SHALL be IDLE, READ and WRITE.
REQ-018 Transitions:
- IDLE->READ on the next edge when Enable=1.
- READ->WRITE on transfer of the last read beat.
- WRITE->READ on transfer of the last write beat if Enable=1, with no bubble; otherwise WRITE->IDLE.
REQ-019 Each phase SHALL emit ORAML+1-TopLevels beats, at levels TopLevels..ORAML in increasing order; OutValid=1 throughout READ and WRITE, and 0 in IDLE.
REQ-020 Leaf SHALL be G[ORAML-1:0], or its bit-reversal when ReverseLex was 1; it is latched at read-phase start and reused for the matching write phase.
REQ-021 OutBID at level l SHALL be (2^l - 1) + (leaf >> (ORAML-l)).
REQ-022 OutIV at level l SHALL be G >> l in READ and (G >> l) + 1 in WRITE, computed modulo 2^AESEntropy.
REQ-023 G SHALL increment by 1 on the transfer of the last write beat; the next read phase uses the new G.
REQ-024 On G wrapping from all-ones to 0, Overflow SHALL set on that edge and hold until Reset.
REQ-025 ReverseLex changes mid-path SHALL have no effect until the next read-phase start.
REQ-026 Enable deasserting mid-path SHALL NOT abort the path; the write phase always completes.
REQ-027 TopLevels=ORAML SHALL yield exactly one beat per phase (leaf bucket only).

Reset
REQ-028 Reset assertion SHALL immediately force: state IDLE, G=0, Overflow=0, PathDone=0, OutValid=0, OutIV=0, OutBID=0, OutLevel=0, OutWrite=0.
REQ-029 Reset mid-path SHALL discard the partial path; no PathDone pulse is emitted and G does not advance.
REQ-030 The first beat after reset release SHALL appear no earlier than 1 cycle after Enable is sampled high in IDLE.

Structure
REQ-031 The IV/BID/level width helpers and the FSM state encoding SHALL live in the shared PathORAM constants package.
REQ-032 The per-level bucket index computation SHALL be a sub-module, bkt_index_calc: combinational in (leaf, level), out BID.
REQ-033 The level counter SHALL reuse the codebase's existing Counter primitive.

Verification
REQ-034 ORAML=3, AESEntropy=8, TopLevels=0, ReverseLex=0, Enable=1, OutReady=1, first path -> read BIDs 0,1,3,7 with IVs 0,0,0,0; write BIDs 0,1,3,7 with IVs 1,1,1,1; PathDone pulses once.
REQ-035 Second path, same setup -> leaf 1: BIDs 0,1,3,8; read IVs 1,0,0,0; write IVs 2,1,1,1.
REQ-036 Second path with ReverseLex=1 -> leaf 4: BIDs 0,2,5,11.
REQ-037 TopLevels=2, first path -> 2 read beats then 2 write beats; levels 2,3; BIDs 3,7.
REQ-038 OutReady toggled randomly with a 30% stall rate -> outputs stable during stalls; beat sequence identical to the no-stall sequence.
REQ-039 Preload G=255, complete one path -> G=0 and Overflow=1; Reset asserted mid-read -> OutValid=0 within the same cycle and G=0.
